psram_qpi_responder: RTL and testbench

PSRAM_QPI_RESPONDER -- requirements
Module: psram_qpi_responder

---
 rtl/psram_qpi_responder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_psram_qpi_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_qpi_responder.sv
// Purpose : PSRAM-style QPI target model: SPI 0x35 enters QPI, QPI 0xF5 exits, 0x38 writes and 0xEB reads a byte array.
// Latency : pin changes are seen 2-3 clk after the pin edge (2-FF sync + edge detect); read nibbles are driven on sclk falls.
// Backpres: none; the initiator owns sclk, and any cs rise aborts the frame within 3 clk.
//
// Ports:
//   clk          system clock, at least 4x the sclk frequency
//   reset        asynchronous, active-high
//   i_psram_cs   chip select from the initiator, active low
//   i_psram_sclk serial clock from the initiator
//   i_sio        SIO[3:0] pin inputs
//   o_sio        SIO[3:0] drive values
//   o_sio_oe     per-pin output enable, 1 = drive
//   o_qpi_mode   1 = QPI mode active
//   o_cmd_err    one-clk pulse on an unsupported command
//
// MEM_ADDR_BITS must lie between 5 and 24.
module psram_qpi_responder #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int WAIT_CYCLES   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_psram_cs,
  input  logic       i_psram_sclk,
  input  logic [3:0] i_sio,
  output logic [3:0] o_sio,
  output logic [3:0] o_sio_oe,
  output logic       o_qpi_mode,
  output logic       o_cmd_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_WAIT,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  // Pin synchronizers. The cs stages reset to 0 (selected) so that a frame
  // already running when reset is released cannot arm the responder.
  logic cs_meta_q, cs_sync_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;

  state_t                   state_q, state_d;
  logic                     armed_q, armed_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [6:0]               cmd_sh_q, cmd_sh_d;
  logic                     is_read_q, is_read_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic                     phase_q, phase_d;
  logic [3:0]               nib_q, nib_d;
  logic                     qpi_q, qpi_d;
  logic                     qpi_set_q, qpi_set_d;
  logic                     qpi_clr_q, qpi_clr_d;
  logic [3:0]               sio_q, sio_d;
  logic [3:0]               oe_q, oe_d;
  logic                     err_q, err_d;
  logic                     mem_we;

  logic [7:0] mem_q [0:(1 << MEM_ADDR_BITS) - 1];

  logic                     sclk_rise, sclk_fall;
  logic [7:0]               cmd_spi, cmd_qpi;
  logic [MEM_ADDR_BITS-1:0] addr_inc;
  logic [7:0]               rd_byte;

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
  // Full command byte as it stands once the current sample is included.
  assign cmd_spi   = {cmd_sh_q, i_sio[0]};
  assign cmd_qpi   = {cmd_sh_q[3:0], i_sio};
  // Natural overflow of the address width gives the wrap to 0.
  assign addr_inc  = addr_q + MEM_ADDR_BITS'(1);
  assign rd_byte   = mem_q[addr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      cmd_sh_q    <= '0;
      is_read_q   <= 1'b0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      nib_q       <= '0;
      qpi_q       <= 1'b0;
      qpi_set_q   <= 1'b0;
      qpi_clr_q   <= 1'b0;
      sio_q       <= '0;
      oe_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      cs_meta_q   <= i_psram_cs;
      cs_sync_q   <= cs_meta_q;
      sclk_meta_q <= i_psram_sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      state_q     <= state_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      cmd_sh_q    <= cmd_sh_d;
      is_read_q   <= is_read_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      nib_q       <= nib_d;
      qpi_q       <= qpi_d;
      qpi_set_q   <= qpi_set_d;
      qpi_clr_q   <= qpi_clr_d;
      sio_q       <= sio_d;
      oe_q        <= oe_d;
      err_q       <= err_d;
    end
  end

  // Array contents survive reset. The write strobe is decoded from state_q,
  // which reset forces to IDLE, so no write can happen during or after reset
  // until a fresh frame starts.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= {nib_q, i_sio};
    end
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | cs_sync_q;
    cnt_d     = cnt_q;
    cmd_sh_d  = cmd_sh_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    nib_d     = nib_q;
    qpi_d     = qpi_q;
    qpi_set_d = qpi_set_q;
    qpi_clr_d = qpi_clr_q;
    sio_d     = sio_q;
    oe_d      = oe_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;

    if (cs_sync_q) begin
      // Deselect wins over everything: drop the bus, discard partial data
      // and commit any mode change requested during the frame.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      phase_d   = 1'b0;
      oe_d      = '0;
      sio_d     = '0;
      qpi_set_d = 1'b0;
      qpi_clr_d = 1'b0;
      if (qpi_set_q) qpi_d = 1'b1;
      if (qpi_clr_q) qpi_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (armed_q) begin
            state_d = ST_CMD;
            cnt_d   = '0;
            phase_d = 1'b0;
          end
        end

        ST_CMD: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 8'd1;
            if (!qpi_q) begin
              cmd_sh_d = {cmd_sh_q[5:0], i_sio[0]};
              if (cnt_q == 8'd7) begin
                cnt_d   = '0;
                state_d = ST_IGNORE;
                if (cmd_spi == 8'h35) qpi_set_d = 1'b1;
                else                  err_d     = 1'b1;
              end
            end else begin
              cmd_sh_d = {cmd_sh_q[2:0], i_sio};
              if (cnt_q == 8'd1) begin
                cnt_d = '0;
                case (cmd_qpi)
                  8'hF5: begin
                    qpi_clr_d = 1'b1;
                    state_d   = ST_IGNORE;
                  end
                  8'h38: begin
                    is_read_d = 1'b0;
                    state_d   = ST_ADDR;
                  end
                  8'hEB: begin
                    is_read_d = 1'b1;
                    state_d   = ST_ADDR;
                  end
                  default: begin
                    err_d   = 1'b1;
                    state_d = ST_IGNORE;
                  end
                endcase
              end
            end
          end
        end

        ST_ADDR: begin
          if (sclk_rise) begin
            // Only the low MEM_ADDR_BITS of the 24-bit address are kept;
            // higher nibbles fall off the top of the shift.
            addr_d = {addr_q[MEM_ADDR_BITS-5:0], i_sio};
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == 8'd5) begin
              cnt_d   = '0;
              phase_d = 1'b0;
              if (!is_read_q)            state_d = ST_WDATA;
              else if (WAIT_CYCLES == 0) state_d = ST_RDATA;
              else                       state_d = ST_WAIT;
            end
          end
        end

        ST_WDATA: begin
          if (sclk_rise) begin
            if (!phase_q) begin
              nib_d   = i_sio;
              phase_d = 1'b1;
            end else begin
              mem_we  = 1'b1;
              addr_d  = addr_inc;
              phase_d = 1'b0;
            end
          end
        end

        ST_WAIT: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == WAIT_LAST) begin
              cnt_d   = '0;
              phase_d = 1'b0;
              state_d = ST_RDATA;
            end
          end
        end

        ST_RDATA: begin
          if (sclk_fall) begin
            oe_d = 4'hF;
            if (!phase_q) begin
              sio_d   = rd_byte[7:4];
              phase_d = 1'b1;
            end else begin
              sio_d   = rd_byte[3:0];
              addr_d  = addr_inc;
              phase_d = 1'b0;
            end
          end
        end

        ST_IGNORE: begin
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign o_sio      = sio_q;
  // Drive is additionally qualified by QPI mode so SPI mode can never drive.
  assign o_sio_oe   = oe_q & {4{qpi_q}};
  assign o_qpi_mode = qpi_q;
  assign o_cmd_err  = err_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
module tb_psram_qpi_responder;

  localparam int MAB   = 10;
  localparam int WAITC = 6;

  logic       clk;
  logic       reset;
  logic       i_psram_cs;
  logic       i_psram_sclk;
  logic [3:0] i_sio;
  logic [3:0] o_sio;
  logic [3:0] o_sio_oe;
  logic       o_qpi_mode;
  logic       o_cmd_err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int oe_cnt = 0;

  psram_qpi_responder #(
    .MEM_ADDR_BITS(MAB),
    .WAIT_CYCLES  (WAITC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_psram_cs  (i_psram_cs),
    .i_psram_sclk(i_psram_sclk),
    .i_sio       (i_sio),
    .o_sio       (o_sio),
    .o_sio_oe    (o_sio_oe),
    .o_qpi_mode  (o_qpi_mode),
    .o_cmd_err   (o_cmd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counters for the error pulse and for any pin drive.
  always @(negedge clk) begin
    if (o_cmd_err === 1'b1) err_cnt++;
    if (o_sio_oe !== 4'h0) oe_cnt++;
  end

  // One sclk period (8 clk): data set while sclk low, held through the high phase.
  task automatic cyc(input logic [3:0] v);
    i_sio = v;
    #40;
    i_psram_sclk = 1'b1;
    #40;
    i_psram_sclk = 1'b0;
  endtask

  // One sclk period, sampling the DUT just before the rising edge.
  task automatic cyc_sample(output logic [3:0] s, output logic [3:0] oe);
    i_sio = 4'h0;
    #40;
    s  = o_sio;
    oe = o_sio_oe;
    i_psram_sclk = 1'b1;
    #40;
    i_psram_sclk = 1'b0;
  endtask

  task automatic frame_start();
    #40;
    i_psram_cs = 1'b0;
    #80;
  endtask

  task automatic frame_end();
    i_psram_cs = 1'b1;
    #30;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]});
  endtask

  task automatic qpi_byte(input logic [7:0] b);
    cyc(b[7:4]);
    cyc(b[3:0]);
  endtask

  task automatic qpi_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) cyc(a[i*4 +: 4]);
  endtask

  task automatic spi_frame(input logic [7:0] b);
    frame_start();
    spi_byte(b);
    frame_end();
  endtask

  task automatic qpi_write2(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
    frame_start();
    qpi_byte(8'h38);
    qpi_addr(a);
    qpi_byte(b0);
    qpi_byte(b1);
    frame_end();
  endtask

  // Read n nibbles (n <= 8); first nibble ends up most significant in rd.
  task automatic qpi_read(input logic [23:0] a, input int n,
                          output logic [31:0] rd, output logic [31:0] oes,
                          output logic [3:0] wait_oe);
    logic [3:0] s, oe;
    rd = '0;
    oes = '0;
    wait_oe = 4'h0;
    frame_start();
    qpi_byte(8'hEB);
    qpi_addr(a);
    for (int i = 0; i < WAITC; i++) begin
      cyc_sample(s, oe);
      wait_oe = wait_oe | oe;
    end
    for (int k = 0; k < n; k++) begin
      cyc_sample(s, oe);
      rd  = {rd[27:0], s};
      oes = {oes[27:0], oe};
    end
    frame_end();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_psram_cs = 1'b1;
    i_psram_sclk = 1'b0;
    i_sio = 4'h0;
    #20;
    n_cmp++; if (o_qpi_mode !== 1'b0) begin $display("FAIL reset_qpi: got %b want 0", o_qpi_mode); n_bad++; end
    n_cmp++; if (o_sio !== 4'h0) begin $display("FAIL reset_sio: got %h want 0", o_sio); n_bad++; end
    n_cmp++; if (o_sio_oe !== 4'h0) begin $display("FAIL reset_oe: got %h want 0", o_sio_oe); n_bad++; end
    n_cmp++; if (o_cmd_err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", o_cmd_err); n_bad++; end
    reset = 1'b0;
    #40;
  endtask

  task automatic test_spi_mode();
    int e0, o0;
    e0 = err_cnt;
    o0 = oe_cnt;
    // 0x38 is not accepted in SPI mode.
    spi_frame(8'h38);
    n_cmp++; if (err_cnt - e0 !== 1) begin $display("FAIL spi_38_err: got %0d pulses want 1", err_cnt - e0); n_bad++; end
    n_cmp++; if (o_qpi_mode !== 1'b0) begin $display("FAIL spi_38_mode: got %b want 0", o_qpi_mode); n_bad++; end
    e0 = err_cnt;
    frame_start();
    spi_byte(8'h35);
    #20;
    n_cmp++; if (o_qpi_mode !== 1'b0) begin $display("FAIL spi_35_early: got %b want 0 before cs rise", o_qpi_mode); n_bad++; end
    i_psram_cs = 1'b1;
    #30;
    n_cmp++; if (o_qpi_mode !== 1'b1) begin $display("FAIL spi_35_mode: got %b want 1 within 3 clk", o_qpi_mode); n_bad++; end
    n_cmp++; if (err_cnt - e0 !== 0) begin $display("FAIL spi_35_err: got %0d pulses want 0", err_cnt - e0); n_bad++; end
    n_cmp++; if (oe_cnt - o0 !== 0) begin $display("FAIL spi_no_drive: got %0d driven clk want 0", oe_cnt - o0); n_bad++; end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, oes;
    logic [3:0]  woe;
    logic [15:0] exp_d;
    exp_d = 16'hA53C;
    qpi_write2(24'h000010, 8'hA5, 8'h3C);
    qpi_read(24'h000010, 4, rd, oes, woe);
    n_cmp++; if (woe !== 4'h0) begin $display("FAIL wr_wait_oe: got %h want 0", woe); n_bad++; end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rd[(3-k)*4 +: 4] !== exp_d[(3-k)*4 +: 4]) begin
        $display("FAIL wr_nib%0d: got %h want %h", k, rd[(3-k)*4 +: 4], exp_d[(3-k)*4 +: 4]); n_bad++; end
      n_cmp++; if (oes[(3-k)*4 +: 4] !== 4'hF) begin
        $display("FAIL wr_oe%0d: got %h want f", k, oes[(3-k)*4 +: 4]); n_bad++; end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, oes;
    logic [3:0]  woe;
    qpi_write2(24'h0003FF, 8'h11, 8'h22);
    qpi_read(24'h0003FF, 4, rd, oes, woe);
    n_cmp++; if (rd[15:0] !== 16'h1122) begin $display("FAIL wrap_read: got %h want 1122", rd[15:0]); n_bad++; end
    qpi_read(24'h000000, 2, rd, oes, woe);
    n_cmp++; if (rd[7:0] !== 8'h22) begin $display("FAIL wrap_mem0: got %h want 22", rd[7:0]); n_bad++; end
    // Upper address bits beyond MEM_ADDR_BITS are ignored.
    qpi_read(24'hABC3FF, 2, rd, oes, woe);
    n_cmp++; if (rd[7:0] !== 8'h11) begin $display("FAIL wrap_hi_addr: got %h want 11", rd[7:0]); n_bad++; end
  endtask

  task automatic test_cmd_err();
    logic [31:0] rd, oes;
    logic [3:0]  woe;
    int e0, o0;
    e0 = err_cnt;
    o0 = oe_cnt;
    frame_start();
    qpi_byte(8'h9F);
    qpi_addr(24'h000010);
    qpi_byte(8'hFF);
    qpi_byte(8'hFF);
    frame_end();
    n_cmp++; if (err_cnt - e0 !== 1) begin $display("FAIL err_pulse: got %0d clk want 1", err_cnt - e0); n_bad++; end
    n_cmp++; if (oe_cnt - o0 !== 0) begin $display("FAIL err_no_drive: got %0d driven clk want 0", oe_cnt - o0); n_bad++; end
    n_cmp++; if (o_qpi_mode !== 1'b1) begin $display("FAIL err_mode: got %b want 1", o_qpi_mode); n_bad++; end
    qpi_read(24'h000010, 4, rd, oes, woe);
    n_cmp++; if (rd[15:0] !== 16'hA53C) begin $display("FAIL err_no_write: got %h want a53c", rd[15:0]); n_bad++; end
    qpi_write2(24'h000020, 8'h5A, 8'hC3);
    qpi_read(24'h000020, 4, rd, oes, woe);
    n_cmp++; if (rd[15:0] !== 16'h5AC3) begin $display("FAIL err_next_frame: got %h want 5ac3", rd[15:0]); n_bad++; end
  endtask

  task automatic test_partial();
    logic [31:0] rd, oes;
    logic [3:0]  woe;
    qpi_write2(24'h000040, 8'h00, 8'h66);
    frame_start();
    qpi_byte(8'h38);
    qpi_addr(24'h000040);
    cyc(4'h7);
    cyc(4'hE);
    cyc(4'h9);
    frame_end();
    qpi_read(24'h000040, 4, rd, oes, woe);
    n_cmp++; if (rd[15:8] !== 8'h7E) begin $display("FAIL partial_first: got %h want 7e", rd[15:8]); n_bad++; end
    n_cmp++; if (rd[7:0] !== 8'h66) begin $display("FAIL partial_second: got %h want 66", rd[7:0]); n_bad++; end
  endtask

  task automatic test_reset_rdata();
    logic [31:0] rd, oes;
    logic [3:0]  woe, s, oe;
    int e0, o0;
    frame_start();
    qpi_byte(8'hEB);
    qpi_addr(24'h000010);
    for (int i = 0; i < WAITC; i++) cyc_sample(s, oe);
    cyc_sample(s, oe);
    n_cmp++; if (s !== 4'hA || oe !== 4'hF) begin $display("FAIL rst_pre_nib: got %h/%h want a/f", s, oe); n_bad++; end
    i_sio = 4'h0;
    #20;
    reset = 1'b1;
    #1;
    n_cmp++; if (o_sio_oe !== 4'h0) begin $display("FAIL rst_oe: got %h want 0", o_sio_oe); n_bad++; end
    n_cmp++; if (o_qpi_mode !== 1'b0) begin $display("FAIL rst_mode: got %b want 0", o_qpi_mode); n_bad++; end
    n_cmp++; if (o_sio !== 4'h0) begin $display("FAIL rst_sio: got %h want 0", o_sio); n_bad++; end
    #19;
    reset = 1'b0;
    // cs still low: the rest of this frame must be ignored.
    e0 = err_cnt;
    o0 = oe_cnt;
    qpi_byte(8'h38);
    qpi_addr(24'h000010);
    qpi_byte(8'h00);
    frame_end();
    n_cmp++; if (oe_cnt - o0 !== 0) begin $display("FAIL rst_stale_drive: got %0d driven clk want 0", oe_cnt - o0); n_bad++; end
    n_cmp++; if (err_cnt - e0 !== 0) begin $display("FAIL rst_stale_err: got %0d pulses want 0", err_cnt - e0); n_bad++; end
    spi_frame(8'h35);
    n_cmp++; if (o_qpi_mode !== 1'b1) begin $display("FAIL rst_reenter: got %b want 1", o_qpi_mode); n_bad++; end
    qpi_read(24'h000010, 4, rd, oes, woe);
    n_cmp++; if (rd[15:0] !== 16'hA53C) begin $display("FAIL rst_retained: got %h want a53c", rd[15:0]); n_bad++; end
  endtask

  task automatic test_exit_qpi();
    int o0;
    o0 = oe_cnt;
    frame_start();
    qpi_byte(8'hF5);
    #20;
    n_cmp++; if (o_qpi_mode !== 1'b1) begin $display("FAIL exit_early: got %b want 1 before cs rise", o_qpi_mode); n_bad++; end
    frame_end();
    n_cmp++; if (o_qpi_mode !== 1'b0) begin $display("FAIL exit_mode: got %b want 0", o_qpi_mode); n_bad++; end
    n_cmp++; if (oe_cnt - o0 !== 0) begin $display("FAIL exit_drive: got %0d driven clk want 0", oe_cnt - o0); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_spi_mode();
    test_write_read();
    test_wrap();
    test_cmd_err();
    test_partial();
    test_reset_rdata();
    test_exit_qpi();
    #50;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
